// File: rtl/zero_cross_pitch_tracker_pkg.sv
// Shared types and constants for the zero-crossing pitch tracker.
package zero_cross_pitch_tracker_pkg;

  localparam int unsigned FREQ_W           = 16;
  localparam int unsigned DEFAULT_MAX_FREQ = 1023;

  // Hysteresis comparator state: which side of the dead band was last seen.
  typedef enum logic {
    NEG = 1'b0,
    POS = 1'b1
  } hyst_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FREQ_W-1:0] sat_inc(input logic [FREQ_W-1:0] val);
    return (val == {FREQ_W{1'b1}}) ? val : val + FREQ_W'(1);
  endfunction

endpackage

// File: rtl/zero_cross_pitch_tracker_hysteresis_comparator.sv
// Two-state hysteresis comparator; pulses rise_pulse on a NEG->POS crossing.
module hysteresis_comparator
  import zero_cross_pitch_tracker_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int HYST     = 256
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid_in,
  output logic                       rise_pulse
);

  localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_NEG = -HYST_POS;

  hyst_state_t r_state;
  hyst_state_t w_state_next;
  logic        w_above;
  logic        w_below;

  // Next state: only valid samples move the FSM; samples exactly at +/-HYST hold.
  always_comb begin
    w_above      = (sample_in > HYST_POS);
    w_below      = (sample_in < HYST_NEG);
    w_state_next = r_state;
    if (sample_valid_in) begin
      case (r_state)
        NEG:     if (w_above) w_state_next = POS;
        POS:     if (w_below) w_state_next = NEG;
        default: w_state_next = NEG;
      endcase
    end
  end

  // State register; reset lands on NEG so a first positive sample counts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= NEG;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Combinational so the counter sees a crossing on the same sample it occurs.
  assign rise_pulse = sample_valid_in && (r_state == NEG) && w_above;

endmodule

// File: rtl/zero_cross_pitch_tracker.sv
// Counts rising zero crossings per window, scales to Hz, smooths, and latches on frame sync.
module zero_cross_pitch_tracker
  import zero_cross_pitch_tracker_pkg::*;
#(
  parameter int SAMPLE_W       = 16,
  parameter int WINDOW_SAMPLES = 3000,
  parameter int SCALE_SHIFT    = 4,
  parameter int HYST           = 256,
  parameter int MAX_FREQ       = DEFAULT_MAX_FREQ,
  parameter int SMOOTH_SHIFT   = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid_in,
  input  logic                       frame_sync_in,
  output logic [FREQ_W-1:0]          freq_out,
  output logic                       update_out,
  output logic                       window_done_out
);

  localparam int WIN_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam int RAW_W = FREQ_W + SCALE_SHIFT;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_SAMPLES - 1);
  localparam logic [RAW_W-1:0]  MAX_WIDE = RAW_W'(MAX_FREQ);
  localparam logic [FREQ_W-1:0] MAX_F    = FREQ_W'(MAX_FREQ);

  logic [WIN_W-1:0]  r_win;
  logic [FREQ_W-1:0] r_cross;
  logic [FREQ_W-1:0] r_raw;
  logic              r_done;
  logic [FREQ_W-1:0] r_smooth;
  logic [FREQ_W-1:0] r_freq;
  logic              r_update;

  logic                     w_rise;
  logic                     w_win_last;
  logic [FREQ_W-1:0]        w_cross_next;
  logic [RAW_W-1:0]         w_scaled;
  logic [FREQ_W-1:0]        w_raw;
  logic signed [FREQ_W:0]   w_diff;
  logic signed [FREQ_W:0]   w_step;
  logic signed [FREQ_W:0]   w_sum;
  logic [FREQ_W-1:0]        w_smooth_next;

  hysteresis_comparator #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST)
  ) u_hyst (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .rise_pulse      (w_rise)
  );

  // Window close, final count (including this sample's crossing) and scaled raw frequency.
  always_comb begin
    w_win_last   = sample_valid_in && (r_win == WIN_LAST);
    w_cross_next = w_rise ? sat_inc(r_cross) : r_cross;
    // Widen before shifting so large counts saturate instead of wrapping.
    w_scaled     = RAW_W'(w_cross_next) << SCALE_SHIFT;
    w_raw        = (w_scaled > MAX_WIDE) ? MAX_F : w_scaled[FREQ_W-1:0];
  end

  // EMA step with arithmetic shift; clamped even though the math keeps it in range.
  always_comb begin
    w_diff = $signed({1'b0, r_raw}) - $signed({1'b0, r_smooth});
    w_step = w_diff >>> SMOOTH_SHIFT;
    w_sum  = $signed({1'b0, r_smooth}) + w_step;
    if (w_sum[FREQ_W]) begin
      w_smooth_next = '0;
    end else if (w_sum[FREQ_W-1:0] > MAX_F) begin
      w_smooth_next = MAX_F;
    end else begin
      w_smooth_next = w_sum[FREQ_W-1:0];
    end
  end

  // Window and crossing counters advance only on valid samples.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_win   <= '0;
      r_cross <= '0;
    end else if (sample_valid_in) begin
      if (w_win_last) begin
        r_win   <= '0;
        r_cross <= '0;
      end else begin
        r_win   <= r_win + WIN_W'(1);
        r_cross <= w_cross_next;
      end
    end
  end

  // Capture the raw frequency at window close; r_done doubles as the debug pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_raw  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_win_last;
      if (w_win_last) begin
        r_raw <= w_raw;
      end
    end
  end

  // Smoothing register updates the cycle after a window closes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_smooth <= '0;
    end else if (r_done) begin
      r_smooth <= w_smooth_next;
    end
  end

  // Frame latch: takes the pre-update smooth value if sync and smoothing coincide.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_freq   <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= frame_sync_in;
      if (frame_sync_in) begin
        r_freq <= r_smooth;
      end
    end
  end

  assign freq_out        = r_freq;
  assign update_out      = r_update;
  assign window_done_out = r_done;

endmodule

// File: tb/tb_zero_cross_pitch_tracker.sv
// Scoreboard bench: three tracker instances (base, SCALE_SHIFT=6, SMOOTH_SHIFT=2) share stimulus.
module tb_zero_cross_pitch_tracker;

  localparam int WIN  = 48;
  localparam int HYST = 256;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] sample = '0;
  logic               valid = 1'b0;
  logic               fs = 1'b0;

  logic [15:0] f0, f1, f2;
  logic        u0, u1, u2;
  logic        d0, d1, d2;

  always #5 clk = ~clk;

  zero_cross_pitch_tracker #(
    .SAMPLE_W(16), .WINDOW_SAMPLES(WIN), .SCALE_SHIFT(4), .HYST(HYST),
    .MAX_FREQ(1023), .SMOOTH_SHIFT(0)
  ) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample), .sample_valid_in(valid),
    .frame_sync_in(fs), .freq_out(f0), .update_out(u0), .window_done_out(d0)
  );

  zero_cross_pitch_tracker #(
    .SAMPLE_W(16), .WINDOW_SAMPLES(WIN), .SCALE_SHIFT(6), .HYST(HYST),
    .MAX_FREQ(1023), .SMOOTH_SHIFT(0)
  ) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample), .sample_valid_in(valid),
    .frame_sync_in(fs), .freq_out(f1), .update_out(u1), .window_done_out(d1)
  );

  zero_cross_pitch_tracker #(
    .SAMPLE_W(16), .WINDOW_SAMPLES(WIN), .SCALE_SHIFT(4), .HYST(HYST),
    .MAX_FREQ(1023), .SMOOTH_SHIFT(2)
  ) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample), .sample_valid_in(valid),
    .frame_sync_in(fs), .freq_out(f2), .update_out(u2), .window_done_out(d2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model state
  int m_state, m_win, m_cross;
  int m_raw[3];
  int m_smooth[3];
  bit m_pend;
  int scale_sh[3]  = '{4, 6, 4};
  int smooth_sh[3] = '{0, 0, 2};
  int q0[$], q1[$], q2[$];
  int n_sync = 0, n_upd = 0, n_done = 0, n_close = 0;

  function automatic int ema(input int sm, input int raw, input int sh);
    int d;
    d  = raw - sm;
    d  = d >>> sh;
    sm = sm + d;
    if (sm < 0) sm = 0;
    if (sm > 1023) sm = 1023;
    return sm;
  endfunction

  function automatic int sq(input int i);
    return ((i % 8) < 4) ? 1000 : -1000;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_win   = 0;
    m_cross = 0;
    m_pend  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_raw[i]    = 0;
      m_smooth[i] = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Drive one cycle and advance the model in the order the hardware sees events.
  task automatic drive(input int s, input bit v, input bit f);
    int r;
    @(negedge clk);
    sample = 16'(s);
    valid  = v;
    fs     = f;
    if (f) begin
      q0.push_back(m_smooth[0]);
      q1.push_back(m_smooth[1]);
      q2.push_back(m_smooth[2]);
      n_sync++;
    end
    if (m_pend) begin
      for (int i = 0; i < 3; i++) m_smooth[i] = ema(m_smooth[i], m_raw[i], smooth_sh[i]);
      m_pend = 1'b0;
    end
    if (v) begin
      if (m_state == 0 && s > HYST) begin
        m_state = 1;
        m_cross++;
      end else if (m_state == 1 && s < -HYST) begin
        m_state = 0;
      end
      if (m_win == WIN - 1) begin
        for (int i = 0; i < 3; i++) begin
          r = m_cross << scale_sh[i];
          m_raw[i] = (r > 1023) ? 1023 : r;
        end
        m_pend  = 1'b1;
        n_close++;
        m_win   = 0;
        m_cross = 0;
      end else begin
        m_win++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
  endtask

  task automatic sync_and_settle();
    idle(1);
    drive(0, 1'b0, 1'b1);
    idle(2);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    fs    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_freq0", int'(f0), 0);
    check_eq("rst_freq1", int'(f1), 0);
    check_eq("rst_freq2", int'(f2), 0);
    check_eq("rst_upd0", int'(u0), 0);
    check_eq("rst_done0", int'(d0), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: pop expected freq on each update pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u0) begin
        n_upd++;
        if (q0.size() == 0) check_eq("upd0_unexpected", 1, 0);
        else check_eq("freq0", int'(f0), q0.pop_front());
      end
      if (u1) begin
        if (q1.size() == 0) check_eq("upd1_unexpected", 1, 0);
        else check_eq("freq1", int'(f1), q1.pop_front());
      end
      if (u2) begin
        if (q2.size() == 0) check_eq("upd2_unexpected", 1, 0);
        else check_eq("freq2", int'(f2), q2.pop_front());
      end
      if (d0 || d1 || d2) begin
        n_done++;
        check_eq("done_align1", int'(d1), int'(d0));
        check_eq("done_align2", int'(d2), int'(d0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_freq0", int'(f0), 0);
    check_eq("reset_upd0", int'(u0), 0);
    check_eq("reset_done0", int'(d0), 0);
    rst_n = 1'b1;

    // 1: square +/-1000, period 8 -> 6 crossings -> 96
    for (int i = 0; i < WIN; i++) drive(sq(i), 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s1_freq", int'(f0), 96);
    check_eq("s1_freq_s6", int'(f1), 384);
    check_eq("s1_freq_ema", int'(f2), 24);
    check_eq("s1_done_cnt", n_done, 1);
    check_eq("s1_upd_cnt", n_upd, 1);

    // 2: amplitude inside the dead band -> 0
    do_reset();
    for (int i = 0; i < WIN; i++) drive(((i % 8) < 4) ? 200 : -200, 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s2_freq", int'(f0), 0);

    // 2b: exactly at +/-HYST must not transition
    for (int i = 0; i < WIN; i++) drive(((i % 2) == 0) ? HYST : -HYST, 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s2b_freq", int'(f0), 0);

    // 3: alternating every sample -> 24 crossings; SCALE_SHIFT=6 clamps at 1023
    do_reset();
    for (int i = 0; i < WIN; i++) drive(((i % 2) == 0) ? 1000 : -1000, 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s3_freq_clamp", int'(f1), 1023);
    check_eq("s3_freq_base", int'(f0), 384);

    // 4: EMA with SMOOTH_SHIFT=2 over two windows -> 24 then 42
    do_reset();
    for (int i = 0; i < WIN; i++) drive(sq(i), 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s4_ema_1", int'(f2), 24);
    for (int i = 0; i < WIN; i++) drive(sq(i), 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s4_ema_2", int'(f2), 42);

    // 5: sparse valids; sync lands on the smoothing cycle -> old value, next sync -> 96
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      drive(sq(i), 1'b1, 1'b0);
      if (i < WIN - 1) idle(2);
    end
    drive(0, 1'b0, 1'b1);
    idle(2);
    check_eq("s5_hold_old", int'(f0), 0);
    drive(0, 1'b0, 1'b1);
    idle(2);
    check_eq("s5_freq", int'(f0), 96);

    // 6: reset mid-window while in POS, then a clean window
    for (int i = 0; i < 20; i++) drive(sq(i), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < WIN; i++) drive(sq(i), 1'b1, 1'b0);
    sync_and_settle();
    check_eq("s6_freq", int'(f0), 96);

    check_eq("q_drain0", q0.size(), 0);
    check_eq("q_drain2", q2.size(), 0);
    check_eq("upd_total", n_upd, n_sync);
    check_eq("done_total", n_done, n_close);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
